// File: rtl/vproc_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vproc_div_seq_if
// Brief    : Word-level valid/ready bundle of the sequential vector divider.
// Revision : 1.0 - initial release
// ============================================================================
interface vproc_div_seq_if #(
    parameter int unsigned DIV_OP_W = 64,
    parameter int unsigned TAG_W    = 8
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DIV_OP_W-1:0]   in_op1_i;
    logic [DIV_OP_W-1:0]   in_op2_i;
    logic [DIV_OP_W/8-1:0] in_mask_i;
    logic [1:0]            in_eew_i;
    logic                  in_rem_i;
    logic                  in_signed_i;
    logic [TAG_W-1:0]      in_tag_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DIV_OP_W-1:0]   out_res_o;
    logic [DIV_OP_W/8-1:0] out_mask_o;
    logic [TAG_W-1:0]      out_tag_o;
    logic                  busy_o;

    modport slave (
        input  in_valid_i, in_op1_i, in_op2_i, in_mask_i, in_eew_i,
               in_rem_i, in_signed_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_res_o, out_mask_o, out_tag_o, busy_o
    );

    modport master (
        output in_valid_i, in_op1_i, in_op2_i, in_mask_i, in_eew_i,
               in_rem_i, in_signed_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_res_o, out_mask_o, out_tag_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/vproc_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : vproc_div_seq
// Brief    : Element-sequential vector integer divider, one shared 32-bit
//            radix-2 restoring datapath, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vproc_div_seq #(
    parameter int unsigned DIV_OP_W = 64,
    parameter int unsigned TAG_W    = 8
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    vproc_div_seq_if.slave   bus
);
    localparam int unsigned N_BYTES = DIV_OP_W / 8;
    localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned SH_W    = IDX_W + 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_OP_W-1:0]   op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [N_BYTES-1:0]    mask_q, mask_d;
    logic [1:0]            eew_q, eew_d;
    logic                  rem_q, rem_d, sgn_q, sgn_d, s1_q, s1_d, s2_q, s2_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           a_q, a_d, b_q, b_d, quo_q, quo_d, rmd_q, rmd_d;
    logic [4:0]            cnt_q, cnt_d;

    logic [2:0]            w_lg;
    logic [31:0]           w_lmask, w_msb, w_e1, w_e2, w_x1, w_x2, w_val, w_qv, w_rv;
    logic [IDX_W-1:0]      w_last;
    logic [SH_W-1:0]       w_sh;
    logic                  w_active, w_n1, w_n2, w_wr;
    logic [32:0]           w_rs;
    logic [DIV_OP_W-1:0]   w_fmask, w_vword;

    // Element geometry derived from the captured element width
    always_comb begin
        case (eew_q)
            2'b00: begin
                w_lg    = 3'd3;
                w_lmask = 32'h0000_00FF;
                w_last  = IDX_W'(N_BYTES - 1);
            end
            2'b01: begin
                w_lg    = 3'd4;
                w_lmask = 32'h0000_FFFF;
                w_last  = IDX_W'(N_BYTES / 2 - 1);
            end
            default: begin
                w_lg    = 3'd5;
                w_lmask = 32'hFFFF_FFFF;
                w_last  = IDX_W'(N_BYTES / 4 - 1);
            end
        endcase
    end

    assign w_sh     = {5'd0, idx_q} << w_lg;
    assign w_msb    = w_lmask & ~(w_lmask >> 1);
    assign w_e1     = 32'(op1_q >> w_sh) & w_lmask;
    assign w_e2     = 32'(op2_q >> w_sh) & w_lmask;
    assign w_active = 1'(mask_q >> w_sh[SH_W-1:3]);
    assign w_n1     = sgn_q & (|(w_e1 & w_msb));
    assign w_n2     = sgn_q & (|(w_e2 & w_msb));
    assign w_x1     = w_n1 ? (w_e1 | ~w_lmask) : w_e1;
    assign w_x2     = w_n2 ? (w_e2 | ~w_lmask) : w_e2;
    assign w_rs     = {rmd_q, a_q[cnt_q]};
    assign w_qv     = (s1_q ^ s2_q) ? (32'd0 - quo_q) : quo_q;
    assign w_rv     = s1_q ? (32'd0 - rmd_q) : rmd_q;

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        mask_d  = mask_q;
        eew_d   = eew_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        w_wr    = 1'b0;
        w_val   = 32'd0;
        w_fmask = '0;
        w_vword = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    op1_d   = bus.in_op1_i;
                    op2_d   = bus.in_op2_i;
                    mask_d  = bus.in_mask_i;
                    eew_d   = bus.in_eew_i;
                    rem_d   = bus.in_rem_i;
                    sgn_d   = bus.in_signed_i;
                    tag_d   = bus.in_tag_i;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!w_active) begin
                    w_wr  = 1'b1;
                end else if (w_e2 == 32'd0) begin
                    w_wr  = 1'b1;
                    w_val = rem_q ? w_e1 : w_lmask;
                end else if (sgn_q && (w_e1 == w_msb) && (w_e2 == w_lmask)) begin
                    w_wr  = 1'b1;
                    w_val = rem_q ? 32'd0 : w_e1;
                end else begin
                    a_d     = w_n1 ? (32'd0 - w_x1) : w_x1;
                    b_d     = w_n2 ? (32'd0 - w_x2) : w_x2;
                    s1_d    = w_n1;
                    s2_d    = w_n2;
                    quo_d   = 32'd0;
                    rmd_d   = 32'd0;
                    cnt_d   = 5'((32'd1 << w_lg) - 32'd1);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // Partial remainder never exceeds 2*|divisor|, so 33 bits suffice
                if (w_rs >= {1'b0, b_q}) begin
                    rmd_d        = 32'(w_rs - {1'b0, b_q});
                    quo_d[cnt_q] = 1'b1;
                end else begin
                    rmd_d = w_rs[31:0];
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                w_wr  = 1'b1;
                w_val = rem_q ? w_rv : w_qv;
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_wr) begin
            w_fmask[31:0] = w_lmask;
            w_vword[31:0] = w_val & w_lmask;
            res_d = (res_q & ~(w_fmask << w_sh)) | (w_vword << w_sh);
            if (idx_q == w_last) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_SETUP;
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            mask_q  <= '0;
            eew_q   <= '0;
            rem_q   <= 1'b0;
            sgn_q   <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            eew_q   <= eew_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.out_res_o   = res_q;
    assign bus.out_mask_o  = mask_q;
    assign bus.out_tag_o   = tag_q;
endmodule
`default_nettype wire

// File: tb/tb_vproc_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vproc_div_seq
// Brief    : Directed self-checking bench for vproc_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vproc_div_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    vproc_div_seq_if #(.DIV_OP_W(64), .TAG_W(8)) bus ();

    vproc_div_seq #(.DIV_OP_W(64), .TAG_W(8)) u_dut (
        .clk_i        (clk),
        .async_rst_ni (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] op1, input logic [63:0] op2, input logic [7:0] mask,
                        input logic [1:0] eew, input logic rem, input logic sgn,
                        input logic [7:0] tag, input string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
        bus.in_op1_i    = op1;
        bus.in_op2_i    = op2;
        bus.in_mask_i   = mask;
        bus.in_eew_i    = eew;
        bus.in_rem_i    = rem;
        bus.in_signed_i = sgn;
        bus.in_tag_i    = tag;
        bus.in_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the inputs so any use of uncaptured values shows up
        bus.in_valid_i  = 1'b0;
        bus.in_op1_i    = {$urandom, $urandom};
        bus.in_op2_i    = {$urandom, $urandom};
        bus.in_mask_i   = 8'($urandom);
        bus.in_eew_i    = 2'($urandom);
        bus.in_rem_i    = ~rem;
        bus.in_signed_i = ~sgn;
        bus.in_tag_i    = ~tag;
    endtask

    task automatic wait_done(input int exp_n, input string nm);
        int lat = 0;
        while (!bus.out_valid_o && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_n));
    endtask

    task automatic check_out(input logic [63:0] res, input logic [7:0] mask,
                             input logic [7:0] tag, input string nm);
        chk({nm, "_res"},  bus.out_res_o, res);
        chk({nm, "_mask"}, 64'(bus.out_mask_o), 64'(mask));
        chk({nm, "_tag"},  64'(bus.out_tag_o), 64'(tag));
        chk({nm, "_rdy_done"}, 64'(bus.in_ready_o), 64'd0);
    endtask

    task automatic ack(input string nm);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        chk({nm, "_valid_drop"}, 64'(bus.out_valid_o), 64'd0);
        chk({nm, "_rdy_back"},   64'(bus.in_ready_o), 64'd1);
    endtask

    task automatic run(input logic [63:0] op1, input logic [63:0] op2, input logic [7:0] mask,
                       input logic [1:0] eew, input logic rem, input logic sgn,
                       input logic [63:0] res, input int exp_n, input string nm);
        logic [7:0] tag;
        tag = 8'($urandom);
        send(op1, op2, mask, eew, rem, sgn, tag, nm);
        wait_done(exp_n, nm);
        check_out(res, mask, tag, nm);
        ack(nm);
    endtask

    initial begin
        logic [63:0] held;
        bus.in_valid_i  = 1'b0;
        bus.in_op1_i    = '0;
        bus.in_op2_i    = '0;
        bus.in_mask_i   = '0;
        bus.in_eew_i    = '0;
        bus.in_rem_i    = 1'b0;
        bus.in_signed_i = 1'b0;
        bus.in_tag_i    = '0;
        bus.out_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_busy",      64'(bus.busy_o), 64'd0);
        chk("rst_res",       bus.out_res_o, 64'd0);
        chk("rst_mask",      64'(bus.out_mask_o), 64'd0);
        chk("rst_tag",       64'(bus.out_tag_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8-bit elements, only byte 0 active: -7/2
        run(64'h1234_5678_9ABC_DEF9, 64'h0000_0000_0000_0002, 8'h01, 2'b00, 1'b0, 1'b1,
            64'h0000_0000_0000_00FD, 17, "s8_div");
        run(64'h1234_5678_9ABC_DEF9, 64'h0000_0000_0000_0002, 8'h01, 2'b00, 1'b1, 1'b1,
            64'h0000_0000_0000_00FF, 17, "s8_rem");
        run(64'h1234_5678_9ABC_DEF9, 64'h0000_0000_0000_0002, 8'h01, 2'b00, 1'b0, 1'b0,
            64'h0000_0000_0000_007C, 17, "u8_div");
        // Divide by zero in both 32-bit elements
        run(64'h0000_0000_0000_0064, 64'h0, 8'hFF, 2'b10, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 2, "u32_dz_div");
        run(64'h0000_0000_0000_0064, 64'h0, 8'hFF, 2'b10, 1'b1, 1'b0,
            64'h0000_0000_0000_0064, 2, "u32_dz_rem");
        // Signed 16-bit overflow case
        run(64'h0000_0000_0000_8000, 64'h0000_0000_0000_FFFF, 8'h01, 2'b01, 1'b0, 1'b1,
            64'h0000_0000_0000_8000, 4, "s16_ovf_div");
        run(64'h0000_0000_0000_8000, 64'h0000_0000_0000_FFFF, 8'h01, 2'b01, 1'b1, 1'b1,
            64'h0, 4, "s16_ovf_rem");
        // 100/7 with element 1 masked off
        run(64'h0000_0005_0000_0064, 64'h0000_0003_0000_0007, 8'h0F, 2'b10, 1'b0, 1'b0,
            64'h0000_0000_0000_000E, 35, "u32_div");
        run(64'h0000_0005_0000_0064, 64'h0000_0003_0000_0007, 8'h0F, 2'b10, 1'b1, 1'b0,
            64'h0000_0000_0000_0002, 35, "u32_rem");
        // Signed 32-bit, both elements: -100/7 and 50/-7
        run(64'h0000_0032_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 8'hFF, 2'b10, 1'b0, 1'b1,
            64'hFFFF_FFF9_FFFF_FFF2, 68, "s32_div");
        run(64'h0000_0032_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 8'hFF, 2'b10, 1'b1, 1'b1,
            64'h0000_0001_FFFF_FFFE, 68, "s32_rem");
        // eew=11 behaves as 32-bit
        run(64'h0000_0005_0000_0064, 64'h0000_0003_0000_0007, 8'h0F, 2'b11, 1'b0, 1'b0,
            64'h0000_0000_0000_000E, 35, "u32b_div");
        // All eight bytes active, one divide-by-zero among them
        run(64'hFF80_640A_0700_3310, 64'h1003_0A03_0705_0001, 8'hFF, 2'b00, 1'b0, 1'b0,
            64'h0F2A_0A03_0100_FF10, 71, "u8_all");

        // Backpressure: DONE holds and refuses new words
        send(64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_0000_0002, 8'h01, 2'b00, 1'b0, 1'b1,
             8'hA5, "bp");
        wait_done(17, "bp");
        held = bus.out_res_o;
        chk("bp_res_first", held, 64'h0000_0000_0000_00FD);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_op1_i   = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp_valid",    64'(bus.out_valid_o), 64'd1);
            chk("bp_res",      bus.out_res_o, held);
            chk("bp_tag",      64'(bus.out_tag_o), 64'hA5);
            chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        ack("bp");
        @(posedge clk);
        #1;
        chk("bp_no_accept", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset in the middle of ITER
        send(64'h0000_0032_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 8'hFF, 2'b10, 1'b0, 1'b1,
             8'h3C, "ar");
        repeat (8) @(posedge clk);
        #3;
        chk("ar_busy_before", 64'(bus.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_in_ready",  64'(bus.in_ready_o), 64'd1);
        chk("ar_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("ar_busy",      64'(bus.busy_o), 64'd0);
        chk("ar_res",       bus.out_res_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(64'hFF80_640A_0700_3310, 64'h1003_0A03_0705_0001, 8'hFF, 2'b00, 1'b0, 1'b0,
            64'h0F2A_0A03_0100_FF10, 71, "ar_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
